// File: rtl/hilo_muldiv.sv
// hilo_muldiv: multi-cycle MULT/MULTU/DIV/DIVU unit owning the HI/LO pair.
// Divider datapath is built only when MULDIV_DIV_EN is defined.
module hilo_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] val1,
  input  logic [WIDTH-1:0] val2,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_sel,
  output logic [WIDTH-1:0] rd_data,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;
  localparam int CW = $clog2(WIDTH + 1);

  state_t             state;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   mag_b;
  logic               neg;
  logic               sgn1, sgn2, accept;
  logic [WIDTH-1:0]   mag1, mag2;
  logic [WIDTH:0]     msum;
  logic [2*WIDTH-1:0] step, prod;
  logic [WIDTH-1:0]   fix_hi, fix_lo;

  assign sgn1 = op[0] & val1[WIDTH-1];
  assign sgn2 = op[0] & val2[WIDTH-1];
  assign mag1 = sgn1 ? -val1 : val1;
  assign mag2 = sgn2 ? -val2 : val2;
  assign busy = (state == RUN) || (state == FIX);
  assign rd_data = rd_sel ? hi : lo;

  // acc = {partial product, remaining multiplier bits}
  assign msum = {1'b0, acc[2*WIDTH-1:WIDTH]}
              + {1'b0, (acc[0] ? mag_b : {WIDTH{1'b0}})};
  assign prod = neg ? -acc : acc;

`ifdef MULDIV_DIV_EN
  logic             is_div, rneg, dz;
  logic [WIDTH:0]   rsh;
  logic [WIDTH+1:0] diff;
  logic [WIDTH-1:0] quo, rem;

  assign accept = start;
  // acc = {partial remainder, dividend/quotient bits}
  assign rsh  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign diff = {1'b0, rsh} - {2'b00, mag_b};
  assign quo  = acc[WIDTH-1:0];
  assign rem  = acc[2*WIDTH-1:WIDTH];

  always_comb begin
    step = {msum, acc[WIDTH-1:1]};
    if (is_div) begin
      if (diff[WIDTH+1])
        step = {rsh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      else
        step = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end
  end

  // divide by zero leaves quotient all ones and remainder = |val1|
  always_comb begin
    fix_hi = prod[2*WIDTH-1:WIDTH];
    fix_lo = prod[WIDTH-1:0];
    if (is_div) begin
      fix_lo = (neg && !dz) ? -quo : quo;
      fix_hi = rneg ? -rem : rem;
    end
  end
`else
  assign accept = start & ~op[1];
  assign step   = {msum, acc[WIDTH-1:1]};
  assign fix_hi = prod[2*WIDTH-1:WIDTH];
  assign fix_lo = prod[WIDTH-1:0];
  assign div_by_zero = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      acc   <= '0;
      mag_b <= '0;
      neg   <= 1'b0;
      hi    <= '0;
      lo    <= '0;
      done  <= 1'b0;
`ifdef MULDIV_DIV_EN
      is_div      <= 1'b0;
      rneg        <= 1'b0;
      dz          <= 1'b0;
      div_by_zero <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
`ifdef MULDIV_DIV_EN
      div_by_zero <= 1'b0;
`endif
      if (!busy) begin
        if (wr_hi) hi <= wr_data;
        if (wr_lo) lo <= wr_data;
      end
      case (state)
        IDLE: if (accept) begin
          state <= RUN;
          cnt   <= CW'(WIDTH);
          acc   <= {{WIDTH{1'b0}}, mag1};
          mag_b <= mag2;
          neg   <= sgn1 ^ sgn2;
`ifdef MULDIV_DIV_EN
          is_div <= op[1];
          rneg   <= sgn1;
          dz     <= op[1] && (val2 == '0);
`endif
        end
        RUN: begin
          acc <= step;
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) state <= FIX;
        end
        FIX: begin
          hi    <= fix_hi;
          lo    <= fix_lo;
          done  <= 1'b1;
          state <= DONE;
`ifdef MULDIV_DIV_EN
          div_by_zero <= is_div & dz;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/hilo_muldiv.md
# hilo_muldiv

Multi-cycle multiply/divide unit owning the architectural HI/LO register pair of the pipelined MIPS core. It sits beside the single-cycle ALU in EXE: the ALU keeps ADD/SUB/AND/SLL, and this block takes MULT/MULTU/DIV/DIVU. It also serves MTHI/MTLO writes and MFHI/MFLO reads. While `busy` is high the hazard unit stalls EXE.

## Interface
- `WIDTH`, 32, operand width; the product is 2*WIDTH, split HI:LO.
- `clk` in 1: rising-edge clock.
- `rst` in 1: synchronous reset, active-low.
- `start` in 1: launch an operation; sampled only in IDLE.
- `op` in 2: 00 MULTU, 01 MULT (signed), 10 DIVU, 11 DIV (signed).
- `val1` in WIDTH: multiplicand or dividend.
- `val2` in WIDTH: multiplier or divisor.
- `wr_hi` in 1: MTHI write strobe.
- `wr_lo` in 1: MTLO write strobe.
- `wr_data` in WIDTH: MTHI/MTLO data.
- `rd_sel` in 1: 0 selects LO, 1 selects HI.
- `rd_data` out WIDTH: combinational read of the selected register (MFHI/MFLO).
- `hi` out WIDTH: HI register.
- `lo` out WIDTH: LO register.
- `busy` out 1: high while the unit is in RUN or FIX.
- `done` out 1: one-cycle completion pulse.
- `div_by_zero` out 1: high with `done` when a divide had divisor 0.

## Operation
- FSM states: IDLE, RUN, FIX, DONE.
  - IDLE -> RUN on `start`: latch `op`, the operand magnitudes (signed ops take abs), and the result sign. Counter loads WIDTH.
  - RUN -> FIX after WIDTH iterations, one per cycle.
  - FIX -> DONE: apply the sign correction and write HI/LO.
  - DONE -> IDLE unconditionally.
- Multiply: radix-2 shift-add on magnitudes into a 2*WIDTH accumulator.
  - Signed product is negated (two's complement over 2*WIDTH) when the operand signs differ.
  - HI = product[2W-1:W], LO = product[W-1:0].
- Divide: restoring shift-subtract on magnitudes. LO = quotient, HI = remainder.
  - Quotient sign = sign(val1) XOR sign(val2).
  - Remainder sign = sign(val1).
  - MIN / -1: LO = MIN, HI = 0, no flag.
- Divide by zero (val2 == 0): HI = val1, LO = all ones, `div_by_zero` = 1 in the DONE cycle. Latency is unchanged.
- MTHI/MTLO: `wr_hi`/`wr_lo` write `wr_data` at the clock edge, only when `busy` = 0.
  - Writes while busy are dropped.
  - A write coinciding with `start` in IDLE takes effect, and is later overwritten by the FIX write.
  - A write during DONE takes effect.
- `start` while not IDLE is ignored. `op`/`val1`/`val2` are don't-care outside the start cycle.
- `rd_data` reflects the registered HI/LO; it shows the old values during RUN/FIX and the new values from the DONE cycle onward.

## Timing
- Reset (`rst` = 0 at an edge), from any state including mid-RUN:
  - state goes to IDLE;
  - `hi` = `lo` = 0, `busy` = `done` = `div_by_zero` = 0;
  - the operation in progress is discarded.
- With the start edge as cycle 0:
  - `busy` = 1 in cycles 1 through WIDTH+1;
  - HI/LO are updated at the end of cycle WIDTH+1;
  - `done` = 1 and `busy` = 0 in cycle WIDTH+2.
- Next earliest accepted `start` is cycle WIDTH+3.
- Total latency is WIDTH+2 cycles (34 for WIDTH = 32), identical for every op.
- `done` and `div_by_zero` are registered. They never assert except in DONE.

## Configuration
- Macro: `MULDIV_DIV_EN`.
- Defined: divider datapath is built and ops 10/11 behave as above.
- Undefined:
  - ops 10/11 are ignored: the FSM stays IDLE, with no `busy` and no `done`, and HI/LO are unchanged;
  - `div_by_zero` is tied 0;
  - multiply behaviour and latency are unchanged.

## Test plan
- Reset: hold `rst` = 0 two cycles -> `hi` = `lo` = 0, `busy` = `done` = 0, `rd_data` = 0.
- MULTU 0xFFFFFFFF × 0x00000002 -> `done` at cycle 34, `hi` = 0x00000001, `lo` = 0xFFFFFFFE; `busy` high exactly cycles 1–33.
- MULT −3 × 5 -> `hi` = 0xFFFFFFFF, `lo` = 0xFFFFFFF1. A `start` pulse at cycle 5 is ignored, and a `wr_hi` of 0x1234 at cycle 6 is dropped.
- DIV −7 / 2 -> `lo` = 0xFFFFFFFD, `hi` = 0xFFFFFFFF. DIVU 5 / 0 -> `lo` = 0xFFFFFFFF, `hi` = 5, `div_by_zero` = 1 with `done`.
- MTLO 0xA5A5A5A5 in IDLE with `rd_sel` = 0 -> `rd_data` = 0xA5A5A5A5 the next cycle.
- Reset mid-operation: start MULTU 7 × 9, drive `rst` = 0 at cycle 10 -> IDLE, `hi` = `lo` = 0, no `done`. A following MULTU 7 × 9 gives `lo` = 63, `hi` = 0.
